// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared FSM state type and default geometry for mpadd_seq
package mpadd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int N_DEFAULT     = 8;
    localparam int WORDS_DEFAULT = 4;

endpackage

// File: rtl/mpadd_seq_cla.sv
// cla: N-bit carry-lookahead adder slice with carry-in and carry-out
module cla #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N-1:0] g, p;
    logic [N:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // each carry is the flat sum-of-products of lower generates and the carry-in
    always_comb begin
        logic t, pp;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & ci);
        end
    end

    assign s  = p ^ c[N-1:0];
    assign co = c[N];

endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: multi-word adder that time-shares one cla over WORDS slices
// MPADD_SUB_EN adds the op port for A-B (B inverted, carry-in forced to 1)
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int WORDS = WORDS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
`ifdef MPADD_SUB_EN
    input  logic               op,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] y,
    output logic               cout,
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t        state, state_n;
    logic [W-1:0]  a_q, b_q;
    logic [IW-1:0] idx;
    logic          carry, sum_co, accept;
    logic [N-1:0]  sum;

    assign accept    = in_valid && in_ready;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign cout      = carry;

    cla #(.N(N)) u_cla (
        .a  (a_q[idx*N +: N]),
        .b  (b_q[idx*N +: N]),
        .ci (carry),
        .s  (sum),
        .co (sum_co)
    );

    always_comb begin
        state_n = state == IDLE ? (accept ? RUN : IDLE)
                : state == RUN  ? (idx == LAST ? DONE : RUN)
                : state == DONE ? (out_ready ? IDLE : DONE)
                : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_q <= a;
                idx <= '0;
`ifdef MPADD_SUB_EN
                b_q   <= op ? ~b : b;
                carry <= op | cin;
`else
                b_q   <= b;
                carry <= cin;
`endif
            end else if (state == RUN) begin
                y[idx*N +: N] <= sum;
                carry         <= sum_co;
                // idx parks on the last word instead of wrapping
                if (idx != LAST) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/mpadd_seq.md
MPADD_SEQ -- requirements
Module: mpadd_seq

Interface
REQ-001 Parameter N, default 8: adder slice width in bits, i.e. the width of the shared cla instance.
REQ-002 Parameter WORDS, default 4: number of N-bit words per operand; total width W = N*WORDS; WORDS >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 a  input  W  operand A, sampled on accept.
REQ-008 b  input  W  operand B, sampled on accept.
REQ-009 cin  input  1  carry-in, sampled on accept.
REQ-010 op  input  1  0 = add, 1 = subtract; present only when MPADD_SUB_EN is defined.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 y  output  W  result.
REQ-014 cout  output  1  carry-out of the most significant word.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch a, b, cin (and op); clear word index to 0; load carry register with cin; go to RUN.
REQ-018 RUN: each cycle, feed word[idx] of A and B plus the carry register to the single cla; write its sum into y word[idx]; load its carry-out into the carry register; increment idx.
REQ-019 RUN exits to DONE on the cycle that processes idx==WORDS-1; idx does not wrap.
REQ-020 Latency: the accept edge is edge 0; out_valid rises after edge WORDS; no other combinational path exists from a/b to y.
REQ-021 DONE: out_valid=1; y and cout = W-bit sum and final carry of a+b+cin; both held stable until the handshake.
REQ-022 DONE with out_ready=1: handshake completes; go to IDLE on that edge.
REQ-023 DONE with out_ready=0: remain in DONE indefinitely.
REQ-024 in_ready=0 in RUN and DONE; in_valid is ignored there, with no overlap between requests.
REQ-025 WORDS=1: exactly one RUN cycle.
REQ-026 y retains its last value in IDLE; cout is driven from the carry register.
REQ-027 Words of y not yet written in RUN are don't-care to consumers.

Reset
REQ-028 rst forces IDLE, idx=0, carry=0, y=0, cout=0, out_valid=0, busy=0, in_ready=1, asynchronously.
REQ-029 rst asserted in RUN or DONE discards the operation; no out_valid is produced for it.

Configuration
REQ-030 Macro MPADD_SUB_EN defined: op port exists; when op=1, B is latched bit-inverted and the carry register is loaded with 1, cin ignored; result is A-B, cout=1 meaning no borrow.
REQ-031 Macro MPADD_SUB_EN undefined: no op port; addition only; no inverter logic.

Structure
REQ-032 Package mpadd_pkg holds the FSM state typedef (IDLE/RUN/DONE) and the default N and WORDS constants.
REQ-033 Exactly one sub-module: the existing cla #(N), instantiated once and time-shared across words.
REQ-034 idx width is $clog2(WORDS), minimum 1 bit.

Verification (N=8, WORDS=4, out_ready=1 unless stated)
REQ-035 a=0x000000FF, b=0x00000001, cin=0 -> out_valid after 4 cycles, y=0x00000100, cout=0.
REQ-036 a=0xFFFFFFFF, b=0x00000000, cin=1 -> y=0x00000000, cout=1; the carry must propagate across all four words.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE -> y and cout stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Reset mid-RUN at idx=2 -> out_valid never asserts; in_ready=1 immediately; next request a=2, b=3 -> y=5.
REQ-039 MPADD_SUB_EN: a=5, b=3, op=1 -> y=2, cout=1; a=3, b=5, op=1 -> y=0xFFFFFFFE, cout=0.
REQ-040 1000 random a, b, cin compared against a behavioral {cout,y}=a+b+cin, with in_valid held high back-to-back; no mismatches and no lost requests.
